// File: rtl/uart_cmd_bridge.sv
`timescale 1ns/1ps
// Host command interpreter: pulls PING/WRITE/READ words from the UART, runs one bus access, returns one status word.
// Waits indefinitely on UART handshakes; bus accesses abort after BUS_TIMEOUT cycles without mem_ack.
module uart_cmd_bridge #(
    parameter int          ADDR_WIDTH  = 32,
    parameter int          BUS_TIMEOUT = 1024,
    parameter logic [31:0] PING_WORD   = 32'h504F4E47
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  uart_read,
    input  logic                  uart_read_response,
    input  logic [31:0]           uart_read_data,
    output logic                  uart_write,
    input  logic                  uart_write_response,
    output logic [31:0]           uart_write_data,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    input  logic                  mem_ack,
    input  logic [31:0]           mem_rdata,
    output logic                  busy
);
    localparam int              CNT_W    = $clog2(BUS_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BUS_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [7:0]      OP_PING  = 8'h01;
    localparam logic [7:0]      OP_WRITE = 8'h02;
    localparam logic [7:0]      OP_READ  = 8'h03;

    typedef enum logic [3:0] {
        IDLE,
        REQ_CMD,
        WAIT_CMD,
        REQ_ADDR,
        WAIT_ADDR,
        REQ_DATA,
        WAIT_DATA,
        BUS,
        SEND,
        WAIT_SEND,
        GUARD
    } state_t;

    state_t                state_q, state_d;
    logic [7:0]            op_q, op_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [31:0]           tx_q, tx_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            op_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            tx_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            tx_q    <= tx_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        tx_d    = tx_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE:     state_d = REQ_CMD;
            REQ_CMD:  state_d = WAIT_CMD;
            WAIT_CMD: begin
                if (uart_read_response) begin
                    op_d = uart_read_data[31:24];
                    case (uart_read_data[31:24])
                        OP_PING: begin
                            tx_d    = PING_WORD;
                            state_d = SEND;
                        end
                        OP_WRITE, OP_READ: state_d = REQ_ADDR;
                        default: begin
                            tx_d    = {8'hEE, uart_read_data[31:24], 16'h0000};
                            state_d = SEND;
                        end
                    endcase
                end
            end
            REQ_ADDR: state_d = WAIT_ADDR;
            WAIT_ADDR: begin
                if (uart_read_response) begin
                    addr_d  = uart_read_data[ADDR_WIDTH-1:0];
                    cnt_d   = '0;
                    state_d = (op_q == OP_WRITE) ? REQ_DATA : BUS;
                end
            end
            REQ_DATA: state_d = WAIT_DATA;
            WAIT_DATA: begin
                if (uart_read_response) begin
                    wdata_d = uart_read_data;
                    cnt_d   = '0;
                    state_d = BUS;
                end
            end
            BUS: begin
                cnt_d = cnt_q + CNT_ONE;
                // An ack in the final allowed cycle still completes the access.
                if (mem_ack) begin
                    tx_d    = (op_q == OP_WRITE) ? 32'h0000_0000 : mem_rdata;
                    state_d = SEND;
                end else if (cnt_q == CNT_LAST) begin
                    tx_d    = 32'hDEADBEEF;
                    state_d = SEND;
                end
            end
            SEND:      state_d = WAIT_SEND;
            WAIT_SEND: if (uart_write_response) state_d = GUARD;
            // Lets the tail of a multi-cycle write response pass before polling again.
            GUARD:     if (!uart_write_response) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    assign uart_read       = (state_q == REQ_CMD) || (state_q == REQ_ADDR) || (state_q == REQ_DATA);
    assign uart_write      = (state_q == SEND);
    assign uart_write_data = tx_q;
    assign mem_req         = (state_q == BUS);
    assign mem_we          = (state_q == BUS) && (op_q == OP_WRITE);
    assign mem_addr        = addr_q;
    assign mem_wdata       = wdata_q;
    assign busy            = (state_q != IDLE);

endmodule

// File: tb/tb_uart_cmd_bridge.sv
`timescale 1ns/1ps
// Bench for uart_cmd_bridge: plays UART host and memory, compares against a command-level model.
module tb_uart_cmd_bridge;
    localparam int          TO   = 8;
    localparam logic [31:0] PING = 32'h504F4E47;

    logic        clk = 1'b0;
    logic        rst;
    logic        uart_read, uart_read_response;
    logic [31:0] uart_read_data;
    logic        uart_write, uart_write_response;
    logic [31:0] uart_write_data;
    logic        mem_req, mem_we, mem_ack, busy;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    uart_cmd_bridge #(.ADDR_WIDTH(32), .BUS_TIMEOUT(TO), .PING_WORD(PING)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .uart_read           (uart_read),
        .uart_read_response  (uart_read_response),
        .uart_read_data      (uart_read_data),
        .uart_write          (uart_write),
        .uart_write_response (uart_write_response),
        .uart_write_data     (uart_write_data),
        .mem_req             (mem_req),
        .mem_we              (mem_we),
        .mem_addr            (mem_addr),
        .mem_wdata           (mem_wdata),
        .mem_ack             (mem_ack),
        .mem_rdata           (mem_rdata),
        .busy                (busy)
    );

    int n_chk = 0;
    int n_err = 0;
    int rd_cnt = 0;
    int wr_cnt = 0;
    int req_cnt = 0;

    // Event counters sampled mid-cycle, used for per-command totals.
    always @(negedge clk) begin
        if (uart_read)  rd_cnt++;
        if (uart_write) wr_cnt++;
        if (mem_req)    req_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] exp_resp(input logic [7:0] op, input logic [31:0] rdata,
                                             input int ack_dly);
        logic acked;
        acked = (ack_dly < TO);
        case (op)
            8'h01:   return PING;
            8'h02:   return acked ? 32'h0000_0000 : 32'hDEADBEEF;
            8'h03:   return acked ? rdata : 32'hDEADBEEF;
            default: return {8'hEE, op, 16'h0000};
        endcase
    endfunction

    task automatic serve_read(input string tag, input logic [31:0] word);
        int n;
        n = 0;
        while (!uart_read && n < 200) begin
            tick();
            n++;
        end
        check({tag, "_rd_req"}, 32'(uart_read), 32'd1);
        tick();
        check({tag, "_rd_pulse"}, 32'(uart_read), 32'd0);
        repeat ($urandom_range(0, 3)) tick();
        uart_read_data     = word;
        uart_read_response = 1'b1;
        tick();
        uart_read_response = 1'b0;
        uart_read_data     = $urandom();
    endtask

    task automatic bus_phase(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [31:0] rdata, input int ack_dly);
        int   n;
        int   k;
        logic bad;
        n   = 0;
        k   = 0;
        bad = 1'b0;
        while (!mem_req && n < 50) begin
            tick();
            n++;
        end
        check("bus_req", 32'(mem_req), 32'd1);
        while (mem_req && k < 2 * TO) begin
            if (mem_we !== we || mem_addr !== addr || (we && mem_wdata !== wdata)) bad = 1'b1;
            if (k == ack_dly) begin
                mem_ack   = 1'b1;
                mem_rdata = rdata;
                tick();
                mem_ack   = 1'b0;
                mem_rdata = $urandom();
                break;
            end
            tick();
            k++;
        end
        check("bus_stable", 32'(bad), 32'd0);
    endtask

    task automatic get_write(input string tag, input logic [31:0] exp, input bit prompt);
        int n;
        n = 0;
        while (!uart_write && n < 50) begin
            tick();
            n++;
        end
        check({tag, "_wr_req"}, 32'(uart_write), 32'd1);
        if (prompt) check({tag, "_latency"}, n, 0);
        check({tag, "_wr_data"}, uart_write_data, exp);
        check({tag, "_busy"}, 32'(busy), 32'd1);
        repeat ($urandom_range(1, 3)) tick();
        uart_write_response = 1'b1;
        tick();
        tick();
        uart_write_response = 1'b0;
        tick();
        check({tag, "_wr_hold"}, uart_write_data, exp);
    endtask

    task automatic run_txn(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] rdata, input int ack_dly);
        int          rd0, wr0, rq0, words, cyc;
        logic [31:0] exp;
        bit          is_bus;
        string       t;
        rd0    = rd_cnt;
        wr0    = wr_cnt;
        rq0    = req_cnt;
        t      = $sformatf("op%02h", op);
        is_bus = (op == 8'h02) || (op == 8'h03);
        exp    = exp_resp(op, rdata, ack_dly);
        words  = (op == 8'h02) ? 3 : (op == 8'h03) ? 2 : 1;
        cyc    = !is_bus ? 0 : (ack_dly < TO) ? ack_dly + 1 : TO;
        serve_read({t, "_cmd"}, {op, 24'($urandom())});
        if (is_bus) serve_read({t, "_addr"}, addr);
        if (op == 8'h02) serve_read({t, "_data"}, wdata);
        if (is_bus) bus_phase(op == 8'h02, addr, wdata, rdata, ack_dly);
        get_write(t, exp, op == 8'h01);
        check({t, "_n_reads"}, rd_cnt - rd0, words);
        check({t, "_n_writes"}, wr_cnt - wr0, 1);
        check({t, "_req_cycles"}, req_cnt - rq0, cyc);
    endtask

    initial begin
        int          n;
        logic [7:0]  op;
        rst                 = 1'b1;
        uart_read_response  = 1'b0;
        uart_read_data      = '0;
        uart_write_response = 1'b0;
        mem_ack             = 1'b0;
        mem_rdata           = '0;
        repeat (3) tick();
        check("rst_uart_read", 32'(uart_read), 32'd0);
        check("rst_uart_write", 32'(uart_write), 32'd0);
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_wr_data", uart_write_data, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        tick();
        check("rd_after_rst", 32'(uart_read), 32'd1);

        run_txn(8'h01, 32'h0, 32'h0, 32'h0, 0);
        run_txn(8'h02, 32'h0000_1000, 32'hCAFEF00D, 32'h0, 3);
        run_txn(8'h03, 32'h0000_0040, 32'h0, 32'h1234_5678, 0);
        run_txn(8'h03, 32'h0000_0080, 32'h0, 32'h5555_AAAA, 100);
        run_txn(8'h03, 32'h0000_0084, 32'h0, 32'h8765_4321, TO - 1);
        run_txn(8'h02, 32'h0000_2000, 32'h0BAD_F00D, 32'h0, 100);
        run_txn(8'h7A, 32'h0, 32'h0, 32'h0, 0);
        run_txn(8'h00, 32'h0, 32'h0, 32'h0, 0);

        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 4))
                0:       op = 8'h01;
                1:       op = 8'h02;
                2:       op = 8'h03;
                default: op = 8'($urandom_range(4, 255));
            endcase
            run_txn(op, $urandom(), $urandom(), $urandom(), $urandom_range(0, TO + 1));
        end

        // Reset while a read is in flight on the bus, then a stale ack.
        serve_read("mid_cmd", 32'h0300_0000);
        serve_read("mid_addr", 32'h0000_0044);
        n = 0;
        while (!mem_req && n < 20) begin
            tick();
            n++;
        end
        check("mid_bus_req", 32'(mem_req), 32'd1);
        tick();
        rst = 1'b1;
        tick();
        check("mid_rst_mem_req", 32'(mem_req), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        mem_ack   = 1'b1;
        mem_rdata = 32'hFEED_FACE;
        rst       = 1'b0;
        tick();
        mem_ack = 1'b0;
        check("late_ack_read", 32'(uart_read), 32'd1);
        check("late_ack_write", 32'(uart_write), 32'd0);
        check("late_ack_mem_req", 32'(mem_req), 32'd0);
        check("late_ack_wr_data", uart_write_data, 32'd0);
        run_txn(8'h01, 32'h0, 32'h0, 32'h0, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
